// File: rtl/text_buffer_arbiter.sv
// Character buffer for the OLED text engine: 4 rows x 16 columns of bytes.
// Two requesters share the single write port through round-robin arbitration.
// A clear sequencer fills the whole buffer with FILL_CHAR.
// Reads are combinational and never stall.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | arbitrate write requests; clearReq starts a sweep
// CLEAR | write FILL_CHAR to cell clrCnt each cycle, 64 cycles in total
module text_buffer_arbiter #(
    parameter logic [7:0] FILL_CHAR      = 8'd32,
    parameter bit         CLEAR_ON_RESET = 1'b1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [5:0] charAddress,
    output logic [7:0] charOutput,
    input  logic       req0,
    input  logic [5:0] addr0,
    input  logic [7:0] data0,
    output logic       gnt0,
    input  logic       req1,
    input  logic [5:0] addr1,
    input  logic [7:0] data1,
    output logic       gnt1,
    input  logic       clearReq,
    output logic       busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t     state;
    logic [5:0] clrCnt;
    logic       lastGnt;
    logic [7:0] mem [64];

    logic       elig0;
    logic       elig1;
    logic       grant0;
    logic       grant1;
    logic       memWe;
    logic [5:0] memAddr;
    logic [7:0] memData;

    // Text engine read port: straight through, same cycle.
    assign charOutput = mem[charAddress];

    // Arbitration and write-port selection. A requester granted last cycle
    // is not eligible, so a held request never collects two grants in a row.
    always_comb begin
        grant0  = 1'b0;
        grant1  = 1'b0;
        memWe   = 1'b0;
        memAddr = clrCnt;
        memData = FILL_CHAR;
        elig0   = req0 & ~gnt0;
        elig1   = req1 & ~gnt1;
        case (state)
            IDLE: begin
                if (!clearReq) begin
                    if (elig0 && elig1) begin
                        grant0 = lastGnt;
                        grant1 = ~lastGnt;
                    end else begin
                        grant0 = elig0;
                        grant1 = elig1;
                    end
                end
                if (grant0) begin
                    memWe   = 1'b1;
                    memAddr = addr0;
                    memData = data0;
                end else if (grant1) begin
                    memWe   = 1'b1;
                    memAddr = addr1;
                    memData = data1;
                end
            end
            CLEAR: begin
                memWe = 1'b1;
            end
            default: begin
                memWe = 1'b0;
            end
        endcase
    end

    // Sequencer state, registered grants and the buffer itself. The buffer
    // has no reset value; keeping it in this block means no cell is written
    // while reset is held, so its contents survive a reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= CLEAR_ON_RESET ? CLEAR : IDLE;
            busy    <= CLEAR_ON_RESET;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            clrCnt  <= 6'd0;
            lastGnt <= 1'b1;
        end else begin
            gnt0 <= grant0;
            gnt1 <= grant1;
            if (memWe) begin
                mem[memAddr] <= memData;
            end
            case (state)
                IDLE: begin
                    if (clearReq) begin
                        state  <= CLEAR;
                        clrCnt <= 6'd0;
                        busy   <= 1'b1;
                    end else if (grant0) begin
                        lastGnt <= 1'b0;
                    end else if (grant1) begin
                        lastGnt <= 1'b1;
                    end
                end
                CLEAR: begin
                    clrCnt <= clrCnt + 6'd1;
                    if (clrCnt == 6'd63) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
